// File: rtl/branch_cond_unit.sv
// -----------------------------------------------------------------------------
// branch_cond_unit
//
// Flag latch and branch-condition evaluator between the ALU and PC-select.
// Z/N/C/V are derived from an ALU result (plus carry/overflow side inputs)
// and optionally latched. A branch request is resolved against the effective
// flags and the decision is registered for one cycle. Taken decisions are
// counted in a saturating performance counter.
//
// Request semantics: br_valid is a single-cycle request with no ready/stall.
// Every cycle with br_valid=1 produces exactly one br_done pulse on the next
// cycle, so requests may be issued back-to-back.
//
// Parameters:
//   WIDTH  ALU result width (>= 2)
//   CNT_W  taken-branch counter width (>= 1)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset, priority over all inputs
//   res        ALU result, source of Z and N
//   carry_in   ALU borrow (1 = unsigned below), source of C
//   ovf_in     ALU signed overflow, source of V
//   flag_we    latch derived flags this cycle (also forwarded to evaluation)
//   br_valid   branch evaluation request
//   br_cond    condition code: EQ NE LT GE LTU GEU AL NV (0..7)
//   cnt_clr    clear taken counter (wins over a simultaneous increment)
//   flags_q    latched flags {N, Z, C, V}
//   br_done    one-cycle pulse: decision available
//   br_taken   decision, forced to 0 when br_done=0
//   taken_cnt  saturating count of taken decisions
// -----------------------------------------------------------------------------
module branch_cond_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] res,
    input  logic             carry_in,
    input  logic             ovf_in,
    input  logic             flag_we,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    input  logic             cnt_clr,
    output logic [3:0]       flags_q,
    output logic             br_done,
    output logic             br_taken,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [2:0] {
        COND_EQ  = 3'b000,
        COND_NE  = 3'b001,
        COND_LT  = 3'b010,
        COND_GE  = 3'b011,
        COND_LTU = 3'b100,
        COND_GEU = 3'b101,
        COND_AL  = 3'b110,
        COND_NV  = 3'b111
    } cond_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [3:0] new_flags;
    logic [3:0] eff_flags;
    logic       f_n;
    logic       f_z;
    logic       f_c;
    logic       f_v;
    logic       cond_true;
    logic       take;

    // Flags freshly derived from this cycle's ALU outputs, {N, Z, C, V}.
    assign new_flags = {res[WIDTH-1], (res == '0), carry_in, ovf_in};

    // Forwarding: a flag write in the same cycle as a request is seen by that
    // request, giving a zero-bubble compare-and-branch.
    assign eff_flags = flag_we ? new_flags : flags_q;

    assign f_n = eff_flags[3];
    assign f_z = eff_flags[2];
    assign f_c = eff_flags[1];
    assign f_v = eff_flags[0];

    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(br_cond))
            COND_EQ:  cond_true = f_z;
            COND_NE:  cond_true = !f_z;
            COND_LT:  cond_true = f_n ^ f_v;
            COND_GE:  cond_true = !(f_n ^ f_v);
            COND_LTU: cond_true = f_c;
            COND_GEU: cond_true = !f_c;
            COND_AL:  cond_true = 1'b1;
            COND_NV:  cond_true = 1'b0;
            default:  cond_true = 1'b0;
        endcase
    end

    assign take = br_valid && cond_true;

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q   <= '0;
            br_done   <= 1'b0;
            br_taken  <= 1'b0;
            taken_cnt <= '0;
        end else begin
            if (flag_we) begin
                flags_q <= new_flags;
            end

            br_done  <= br_valid;
            br_taken <= take;

            if (cnt_clr) begin
                taken_cnt <= '0;
            end else if (take && (taken_cnt != CNT_MAX)) begin
                taken_cnt <= taken_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
module tb_branch_cond_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT: WIDTH=32, CNT_W=16
    logic        rst;
    logic [31:0] res;
    logic        carry_in;
    logic        ovf_in;
    logic        flag_we;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic        cnt_clr;
    logic [3:0]  flags_q;
    logic        br_done;
    logic        br_taken;
    logic [15:0] taken_cnt;

    // saturation DUT: WIDTH=32, CNT_W=2
    logic        s_rst;
    logic        s_br_valid;
    logic [2:0]  s_br_cond;
    logic        s_cnt_clr;
    logic [3:0]  s_flags_q;
    logic        s_br_done;
    logic        s_br_taken;
    logic [1:0]  s_taken_cnt;

    branch_cond_unit #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .res(res), .carry_in(carry_in), .ovf_in(ovf_in),
        .flag_we(flag_we), .br_valid(br_valid), .br_cond(br_cond), .cnt_clr(cnt_clr),
        .flags_q(flags_q), .br_done(br_done), .br_taken(br_taken), .taken_cnt(taken_cnt)
    );

    branch_cond_unit #(.WIDTH(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(s_rst), .res(32'h0), .carry_in(1'b0), .ovf_in(1'b0),
        .flag_we(1'b0), .br_valid(s_br_valid), .br_cond(s_br_cond), .cnt_clr(s_cnt_clr),
        .flags_q(s_flags_q), .br_done(s_br_done), .br_taken(s_br_taken),
        .taken_cnt(s_taken_cnt)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        res = 32'h0; carry_in = 1'b0; ovf_in = 1'b0; flag_we = 1'b0;
        br_valid = 1'b0; br_cond = 3'b000; cnt_clr = 1'b0;
    endtask

    task automatic sat_branch(input logic clr);
        s_br_valid = 1'b1; s_br_cond = 3'b110; s_cnt_clr = clr;
        tick();
        s_br_valid = 1'b0; s_cnt_clr = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        fwe;
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        bv;
        logic [2:0]  cond;
        logic        clr;
        logic [3:0]  e_flags;
        logic        e_done;
        logic        e_taken;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[18];

    initial begin
        // zero compare: taken, then not taken
        vecs[0]  = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'b0100, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 4'b0100, 1'b1, 1'b1, 16'd1};
        vecs[2]  = '{1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd1};
        vecs[3]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 4'b0000, 1'b1, 1'b0, 16'd1};
        // forwarding: Z=1 latched, same-cycle write of negative result + LT
        vecs[4]  = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'b0100, 1'b0, 1'b0, 16'd1};
        vecs[5]  = '{1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 4'b1000, 1'b1, 1'b1, 16'd2};
        // code sweep on flags 1011
        vecs[6]  = '{1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 4'b1011, 1'b0, 1'b0, 16'd2};
        vecs[7]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 4'b1011, 1'b1, 1'b0, 16'd2};
        vecs[8]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 4'b1011, 1'b1, 1'b1, 16'd3};
        vecs[9]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 4'b1011, 1'b1, 1'b0, 16'd3};
        vecs[10] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 4'b1011, 1'b1, 1'b1, 16'd4};
        vecs[11] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 4'b1011, 1'b1, 1'b1, 16'd5};
        vecs[12] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 3'b101, 1'b0, 4'b1011, 1'b1, 1'b0, 16'd5};
        vecs[13] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 3'b110, 1'b0, 4'b1011, 1'b1, 1'b1, 16'd6};
        vecs[14] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 4'b1011, 1'b1, 1'b0, 16'd6};
        // pulse ends, clear beats a taken increment, forwarded C for LTU
        vecs[15] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 4'b1011, 1'b0, 1'b0, 16'd6};
        vecs[16] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 3'b110, 1'b1, 4'b1011, 1'b1, 1'b1, 16'd0};
        vecs[17] = '{1'b1, 32'h0000_0005, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 4'b0010, 1'b1, 1'b1, 16'd1};
    end

    // ---------------- test sequence ----------------
    initial begin
        idle_inputs();
        s_br_valid = 1'b0; s_br_cond = 3'b000; s_cnt_clr = 1'b0;

        // reset with a branch and a flag write pending: both discarded
        rst = 1'b1; s_rst = 1'b1;
        br_valid = 1'b1; br_cond = 3'b110; flag_we = 1'b1; res = 32'h0;
        tick();
        rst = 1'b0; s_rst = 1'b0;
        idle_inputs();
        check("rst_flags", {28'h0, flags_q}, 32'h0);
        check("rst_done", {31'h0, br_done}, 32'h0);
        check("rst_taken", {31'h0, br_taken}, 32'h0);
        check("rst_cnt", {16'h0, taken_cnt}, 32'h0);

        // table-driven vectors
        for (int i = 0; i < 18; i++) begin
            flag_we = vecs[i].fwe; res = vecs[i].r; carry_in = vecs[i].c; ovf_in = vecs[i].v;
            br_valid = vecs[i].bv; br_cond = vecs[i].cond; cnt_clr = vecs[i].clr;
            exp_q.push_back(vecs[i].e_cnt);
            tick();
            idle_inputs();
            check($sformatf("v%0d_flags", i), {28'h0, flags_q}, {28'h0, vecs[i].e_flags});
            check($sformatf("v%0d_done", i), {31'h0, br_done}, {31'h0, vecs[i].e_done});
            check($sformatf("v%0d_taken", i), {31'h0, br_taken}, {31'h0, vecs[i].e_taken});
            check($sformatf("v%0d_cnt", i), {16'h0, taken_cnt}, {16'h0, exp_q.pop_front()});
        end

        // mid-stream reset: no stale br_done, counter and flags cleared
        br_valid = 1'b1; br_cond = 3'b110; rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        check("mid_rst_done", {31'h0, br_done}, 32'h0);
        check("mid_rst_taken", {31'h0, br_taken}, 32'h0);
        check("mid_rst_cnt", {16'h0, taken_cnt}, 32'h0);
        check("mid_rst_flags", {28'h0, flags_q}, 32'h0);

        // saturation on the CNT_W=2 instance: 1,2,3,3,3
        exp_q.push_back(16'd1); exp_q.push_back(16'd2); exp_q.push_back(16'd3);
        exp_q.push_back(16'd3); exp_q.push_back(16'd3);
        for (int k = 0; k < 5; k++) begin
            sat_branch(1'b0);
            check($sformatf("sat_cnt%0d", k), {30'h0, s_taken_cnt}, {16'h0, exp_q.pop_front()});
            check($sformatf("sat_taken%0d", k), {31'h0, s_br_taken}, 32'h1);
        end

        // clear together with a taken branch at the saturated value
        sat_branch(1'b1);
        check("clr_cnt", {30'h0, s_taken_cnt}, 32'h0);
        check("clr_taken", {31'h0, s_br_taken}, 32'h1);
        check("clr_done", {31'h0, s_br_done}, 32'h1);

        // counting resumes after the clear
        sat_branch(1'b0);
        check("post_clr_cnt", {30'h0, s_taken_cnt}, 32'h1);

        // idle cycle: decision pulse drops
        tick();
        check("sat_idle_done", {31'h0, s_br_done}, 32'h0);
        check("sat_idle_taken", {31'h0, s_br_taken}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Parametrised branch-condition unit for the RISC datapath, generalising the single-purpose zero detector into a full flag/condition evaluator. It latches Z/N/C/V flags from any ALU result and evaluates eight condition codes against them. Branch requests get a registered taken/not-taken decision one cycle later, with same-cycle flag forwarding. A saturating taken-branch counter is provided for performance monitoring. It sits between the ALU output and the PC-select logic.

## Interface

Parameters:
- WIDTH, 32, ALU result width (≥2)
- CNT_W, 16, width of taken-branch counter (≥1)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- res  input  WIDTH  ALU result to derive Z and N
- carry_in  input  1  ALU borrow for subtract/compare (1 = unsigned below)
- ovf_in  input  1  ALU signed-overflow flag
- flag_we  input  1  latch flags from res/carry_in/ovf_in this cycle
- br_valid  input  1  branch evaluation request
- br_cond  input  3  condition code for the request
- cnt_clr  input  1  clear taken counter
- flags_q  output  4  latched flags {N, Z, C, V}
- br_done  output  1  one-cycle pulse: decision available
- br_taken  output  1  decision; meaningful only while br_done=1, else 0
- taken_cnt  output  CNT_W  saturating count of taken decisions

## Operation

- Flag derivation: Z = (res == 0), N = res[WIDTH-1], C = carry_in, V = ovf_in.
- flag_we=1: flags_q <= {N,Z,C,V}; otherwise flags_q holds.
- Effective flags for evaluation: new derived flags if flag_we=1 in the same cycle (forwarding), else flags_q.
- Condition codes (on effective flags):
  - 000 EQ: Z
  - 001 NE: !Z
  - 010 LT: N ^ V
  - 011 GE: !(N ^ V)
  - 100 LTU: C
  - 101 GEU: !C
  - 110 AL: 1
  - 111 NV: 0
- br_valid=1: br_done <= 1, br_taken <= condition result; br_valid=0: br_done <= 0, br_taken <= 0.
- No backpressure; one request accepted every cycle, back-to-back allowed.
- Counter: when a taken decision is registered (br_valid=1 and condition true), taken_cnt increments by 1. It holds at 2^CNT_W-1 (saturate, never wraps).
- cnt_clr=1: taken_cnt <= 0. Clear wins over a simultaneous increment.
- Reset: flags_q=0, br_done=0, br_taken=0, taken_cnt=0. rst has priority over all inputs.
  - A br_valid or flag_we in the reset cycle is discarded.
  - br_done is 0 in the cycle after reset.

## Timing

- flag_we at edge t → flags_q updated after edge t (visible in cycle t+1).
- br_valid at edge t → br_done/br_taken valid in cycle t+1 for exactly one cycle. Latency 1, throughput 1/cycle.
- Same-cycle flag_we + br_valid: the decision uses the new flags. Zero-bubble compare-and-branch.
- taken_cnt updates on the same edge as the corresponding br_taken; visible in cycle t+1.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-stream: outputs are zero from the following cycle; no stale br_done.

## Test plan

- Reset: assert rst with br_valid=1, flag_we=1, res=0. Next cycle: flags_q=0000, br_done=0, br_taken=0, taken_cnt=0.
- Zero compare, WIDTH=32: flag_we=1, res=0, then br_valid with cond=000. Response: flags_q=0100, br_done=1, br_taken=1, taken_cnt=1. Repeat with res=32'h0000_0001: flags_q=0000, br_taken=0, taken_cnt unchanged.
- Forwarding: flags_q holds Z=1. In the same cycle, flag_we=1 with res=32'h8000_0000, ovf_in=0, and br_valid with cond=010 (LT). Response: br_taken=1, flags_q=1000.
- Code sweep: flags {N,Z,C,V}=1011, all eight codes issued back-to-back. br_taken sequence must be 0,1,0,1,1,0,1,0, with br_done=1 on eight consecutive cycles.
- Saturation, CNT_W=2: issue five consecutive AL branches. taken_cnt must read 1,2,3,3,3.
- Clear priority: cnt_clr=1 together with a taken branch at taken_cnt=3. Next cycle: taken_cnt=0, br_taken=1.
